// File: rtl/fp_alu_pkg.sv
// Shared types, default format constants and operand classification for the FP ALU squarer.
// Optional rounding mode is selected with FP_SQR_RNE_EN (see fp_sq_round).
package fp_alu_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} sq_state_e;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int BIAS      = 2**(DEF_EXP_W-1) - 1;

  localparam logic [DEF_EXP_W+DEF_MAN_W:0] QNAN = {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_MAN_W-1){1'b0}}};
  localparam logic [DEF_EXP_W+DEF_MAN_W:0] PINF = {1'b0, {DEF_EXP_W{1'b1}}, {DEF_MAN_W{1'b0}}};

  // Denormals are grouped with zero because the squarer flushes them.
  function automatic fp_class_e fp_classify(input logic expZero, input logic expOnes, input logic fracZero);
    if (expZero)
      return FP_ZERO;
    else if (expOnes)
      return fracZero ? FP_INF : FP_NAN;
    else
      return FP_NORM;
  endfunction

endpackage

// File: rtl/fp_sq_round.sv
// Combinational normalise / round / range check for the squarer product.
// FP_SQR_RNE_EN defined: round-to-nearest-even; undefined: truncation.
module fp_sq_round import fp_alu_pkg::*; #(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic [2*MAN_W+1:0]      p,
  input  logic signed [EXP_W+1:0] e,
  output logic [EXP_W+MAN_W:0]    result,
  output logic                    ovf,
  output logic                    unf
);

  localparam int PW = 2*MAN_W + 2;
  localparam logic signed [EXP_W+1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

  logic [PW-1:0]           pNorm;
  logic signed [EXP_W+1:0] eNorm;
  logic signed [EXP_W+1:0] eFinal;
  logic [MAN_W-1:0]        frac;
  logic [MAN_W-1:0]        fracFinal;
  logic                    unusedBits;
`ifdef FP_SQR_RNE_EN
  logic                    guardBit;
  logic                    stickyBit;
  logic                    roundUp;
  logic [MAN_W:0]          fracSum;
`endif

  // Left-align the product so the hidden bit always sits at pNorm[PW-1].
  always_comb begin
    pNorm = p[PW-1] ? p : (p << 1);
    eNorm = e + $signed({{(EXP_W+1){1'b0}}, p[PW-1]});
    frac  = pNorm[PW-2 -: MAN_W];
`ifdef FP_SQR_RNE_EN
    unusedBits = pNorm[PW-1];
    guardBit   = pNorm[PW-2-MAN_W];
    stickyBit  = |pNorm[PW-3-MAN_W:0];
    roundUp    = guardBit & (stickyBit | frac[0]);
    fracSum    = {1'b0, frac} + {{MAN_W{1'b0}}, roundUp};
    fracFinal  = fracSum[MAN_W-1:0];
    eFinal     = eNorm + $signed({{(EXP_W+1){1'b0}}, fracSum[MAN_W]});
`else
    unusedBits = pNorm[PW-1] ^ (^pNorm[PW-2-MAN_W:0]);
    fracFinal  = frac;
    eFinal     = eNorm;
`endif
    ovf    = 1'b0;
    unf    = 1'b0;
    if (eFinal >= EXP_MAX) begin
      result = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf    = 1'b1;
    end else if (eFinal <= EXP_ZERO) begin
      result = '0;
      unf    = 1'b1;
    end else begin
      result = {1'b0, eFinal[EXP_W-1:0], fracFinal};
    end
  end

endmodule

// File: rtl/fp_square_seq.sv
// Sequential IEEE-754 squarer: radix-2 shift-add mantissa multiply, one partial product per cycle.
// FP_SQR_RNE_EN selects round-to-nearest-even instead of truncation.
module fp_square_seq import fp_alu_pkg::*; #(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 ovf,
  output logic                 unf
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2*MAN_W + 2;
  localparam int CW = $clog2(MAN_W + 1);
  localparam logic [CW-1:0]          LAST_CNT = CW'(MAN_W);
  localparam logic signed [EXP_W+1:0] BIAS_S  = (EXP_W+2)'(2**(EXP_W-1) - 1);
  localparam logic [W-1:0] QNAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0] PINF_W = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  sq_state_e               state;
  logic [EXP_W-1:0]        expReg;
  logic [MAN_W:0]          mant;
  logic [PW-1:0]           acc;
  logic [CW-1:0]           cnt;
  logic signed [EXP_W+1:0] expSq;
  logic [W-1:0]            roundResult;
  logic                    roundOvf;
  logic                    roundUnf;
  logic [EXP_W-1:0]        aExp;
  logic [MAN_W-1:0]        aFrac;
  logic                    unusedSign;
  fp_class_e               aClass;

  // The sign never matters: squares are always non-negative.
  assign aExp       = a[W-2 -: EXP_W];
  assign aFrac      = a[MAN_W-1:0];
  assign unusedSign = a[W-1];
  assign aClass     = fp_classify(aExp == '0, &aExp, aFrac == '0);
  assign expSq      = $signed({1'b0, expReg, 1'b0}) - BIAS_S;

  fp_sq_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) uRound (
    .p      (acc),
    .e      (expSq),
    .result (roundResult),
    .ovf    (roundOvf),
    .unf    (roundUnf)
  );

  // Control FSM; specials bypass the multiply and finish on the cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      mant      <= '0;
      expReg    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            expReg <= aExp;
            mant   <= {1'b1, aFrac};
            acc    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            in_ready <= 1'b0;
            unique case (aClass)
              FP_ZERO: begin result <= '0;     out_valid <= 1'b1; state <= DONE; end
              FP_INF:  begin result <= PINF_W; out_valid <= 1'b1; state <= DONE; end
              FP_NAN:  begin result <= QNAN_W; out_valid <= 1'b1; state <= DONE; end
              default: state <= MUL;
            endcase
          end
        end
        MUL: begin
          if (mant[cnt])
            acc <= acc + (PW'(mant) << cnt);
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT)
            state <= NORM;
        end
        NORM: begin
          result    <= roundResult;
          ovf       <= roundOvf;
          unf       <= roundUnf;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_square_seq.sv
// Self-checking bench for fp_square_seq: directed cases plus random operands against an integer reference model.
module tb_fp_square_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        unf;

  int checkCount = 0;
  int failCount  = 0;

  fp_square_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference: exact integer square of the significand, then IEEE normalise/round/range rules.
  function automatic void refSquare(input logic [31:0] x, output logic [31:0] r,
                                    output logic o, output logic u, output int lat);
    logic [7:0]      ex;
    logic [22:0]     fr;
    longint unsigned mm;
    longint unsigned p;
    longint unsigned fq;
    int              e;
    int              sh;
`ifdef FP_SQR_RNE_EN
    longint unsigned rem;
    longint unsigned half;
`endif
    ex = x[30:23];
    fr = x[22:0];
    o = 1'b0; u = 1'b0; lat = 0; r = '0;
    if (ex == 8'h00) begin
      r = 32'h0000_0000;
    end else if (ex == 8'hFF) begin
      r = (fr != 0) ? 32'h7FC0_0000 : 32'h7F80_0000;
    end else begin
      lat = 25;
      mm  = 64'(fr) + (64'd1 << 23);
      p   = mm * mm;
      e   = 2 * int'(ex) - 127;
      if (p >= (64'd1 << 47)) begin e++; sh = 24; end
      else sh = 23;
      fq = (p >> sh) - (64'd1 << 23);
`ifdef FP_SQR_RNE_EN
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && fq[0])) fq++;
      if (fq == (64'd1 << 23)) begin fq = 0; e++; end
`endif
      if (e >= 255) begin r = 32'h7F80_0000; o = 1'b1; end
      else if (e <= 0) begin r = 32'h0000_0000; u = 1'b1; end
      else r = {1'b0, 8'(e), fq[22:0]};
    end
  endfunction

  // Issue one operand, measure latency, optionally stall the result, then hand it off.
  task automatic applyStimulus(input logic [31:0] aVal, input int holdCycles,
                               output logic [31:0] res, output logic o, output logic u, output int lat);
    int waitCnt;
    @(negedge clk);
    waitCnt = 0;
    while (!in_ready && waitCnt < 100) begin @(negedge clk); waitCnt++; end
    checkOutput("inReadyBeforeIssue", 32'(in_ready), 32'd1);
    a = aVal;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    res = result; o = ovf; u = unf;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h4000_0000;
      checkOutput("holdResult", result, res);
      checkOutput("holdInReady", 32'(in_ready), 32'd0);
      checkOutput("holdOutValid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("outValidDrop", 32'(out_valid), 32'd0);
  endtask

  task automatic runCase(input string name, input logic [31:0] aVal, input logic [31:0] expR,
                         input logic expO, input logic expU, input int expLat, input int holdCycles);
    logic [31:0] r;
    logic        o, u;
    int          lat;
    applyStimulus(aVal, holdCycles, r, o, u, lat);
    checkOutput($sformatf("%s result a=%h", name, aVal), r, expR);
    checkOutput($sformatf("%s ovf a=%h", name, aVal), 32'(o), 32'(expO));
    checkOutput($sformatf("%s unf a=%h", name, aVal), 32'(u), 32'(expU));
    checkOutput($sformatf("%s latency a=%h", name, aVal), 32'(lat), 32'(expLat));
  endtask

  task automatic runModelCase(input logic [31:0] aVal);
    logic [31:0] r;
    logic        o, u;
    int          lat;
    refSquare(aVal, r, o, u, lat);
    runCase("rand", aVal, r, o, u, lat, 0);
  endtask

  initial begin
    logic [31:0] rndA;
    logic [31:0] expRound;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetInReady", 32'(in_ready), 32'd1);
    checkOutput("resetOutValid", 32'(out_valid), 32'd0);
    checkOutput("resetResult", result, 32'd0);
    checkOutput("resetFlags", {30'd0, ovf, unf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runCase("three", 32'h4040_0000, 32'h4110_0000, 1'b0, 1'b0, 25, 0);
    runCase("minusTwo", 32'hC000_0000, 32'h4080_0000, 1'b0, 1'b0, 25, 0);
    runCase("oneHalf", 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, 25, 0);
    runCase("posInf", 32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0, 0, 0);
    runCase("negNan", 32'hFFC0_0000, 32'h7FC0_0000, 1'b0, 1'b0, 0, 0);
    runCase("negZero", 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 0, 0);
    runCase("overflow", 32'h60AD_78EC, 32'h7F80_0000, 1'b1, 1'b0, 25, 0);
    runCase("underflow", 32'h0D80_0000, 32'h0000_0000, 1'b0, 1'b1, 25, 0);
`ifdef FP_SQR_RNE_EN
    expRound = 32'h3F80_1003;
`else
    expRound = 32'h3F80_1002;
`endif
    runCase("rounding", 32'h3F80_0801, expRound, 1'b0, 1'b0, 25, 0);
    runCase("stall", 32'h4040_0000, 32'h4110_0000, 1'b0, 1'b0, 25, 10);

    // Abort mid-multiply: reset must discard the partial product.
    @(negedge clk);
    a = 32'h4040_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetInReady", 32'(in_ready), 32'd1);
    checkOutput("midResetOutValid", 32'(out_valid), 32'd0);
    checkOutput("midResetResult", result, 32'd0);
    checkOutput("midResetFlags", {30'd0, ovf, unf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    runCase("afterReset", 32'h4040_0000, 32'h4110_0000, 1'b0, 1'b0, 25, 0);

    for (int i = 0; i < 40; i++) begin
      rndA = $urandom;
      if (i % 4 == 0) rndA[30:23] = 8'($urandom_range(100, 154));
      if (i % 10 == 3) rndA[22:0] = '0;
      runModelCase(rndA);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
